// File: rtl/sdram_pkg.sv
// Shared SDRAM command types: command layout, burst length and data width
// used by the requesters, the arbiter and the controller.
package sdram_pkg;

    localparam int BURST_LEN  = 8;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 24;

    localparam logic READ_CMD  = 1'b1;
    localparam logic WRITE_CMD = 1'b0;

    // 1 + 24 + 16 + 1 = 42 bits
    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  auto_pre;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle of requester-side, controller-side and read-return signals of the
// SDRAM command arbiter; slave is the arbiter's view, master the environment's.
interface sdram_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int CMD_W  = $bits(sdram_pkg::sdram_cmd_t);
    localparam int DATA_W = sdram_pkg::DATA_WIDTH;

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*CMD_W-1:0] req_cmd_i;
    logic                     ctrl_valid_o;
    logic                     ctrl_ready_i;
    logic [CMD_W-1:0]         ctrl_cmd_o;
    logic                     rd_valid_i;
    logic [DATA_W-1:0]        rd_data_i;
    logic [NUM_REQ-1:0]       rd_valid_o;
    logic [DATA_W-1:0]        rd_data_o;
    logic                     err_o;

    modport slave (
        input  req_valid_i, req_cmd_i, ctrl_ready_i, rd_valid_i, rd_data_i,
        output req_ready_o, ctrl_valid_o, ctrl_cmd_o, rd_valid_o, rd_data_o, err_o
    );

    modport master (
        output req_valid_i, req_cmd_i, ctrl_ready_i, rd_valid_i, rd_data_i,
        input  req_ready_o, ctrl_valid_o, ctrl_cmd_o, rd_valid_o, rd_data_o, err_o
    );

endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Round-robin SDRAM command arbiter with beat-locked write bursts and a tag FIFO
// that steers read returns. Define SDRAM_ARB_PRIO0_EN to give requester 0 fixed priority.
module sdram_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = sdram_pkg::BURST_LEN,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    sdram_cmd_arbiter_if.slave  bus
);

    localparam int CMD_W  = $bits(sdram_pkg::sdram_cmd_t);
    localparam int DATA_W = sdram_pkg::DATA_WIDTH;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [PTR_W:0]    TAG_FULL  = (PTR_W + 1)'(TAG_DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t               state_r, state_nx_s;
    logic [IDX_W-1:0]     grant_r, grant_nx_s;
    logic [IDX_W-1:0]     last_grant_r, last_nx_s;
    logic                 burst_rw_r, rw_nx_s;
    logic [BEAT_W-1:0]    beat_cnt_r, beat_nx_s;

    logic [IDX_W-1:0]     tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]       tag_cnt_r;
    logic [BEAT_W-1:0]    rd_beat_r;
    logic [NUM_REQ-1:0]   rd_valid_r;
    logic [DATA_W-1:0]    rd_data_r;
    logic                 err_r;

    sdram_pkg::sdram_cmd_t cmd_s [NUM_REQ];
    sdram_pkg::sdram_cmd_t ctrl_cmd_s;
    logic [NUM_REQ-1:0]   elig_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic                 ctrl_valid_s;
    logic                 tag_full_s, tag_empty_s;
    logic [IDX_W-1:0]     rr_pick_s, pick_s, pos_s;
    logic                 pick_vld_s;
    logic                 push_s, pop_s, rd_hit_s;
    logic [IDX_W-1:0]     head_tag_s;
    logic [NUM_REQ-1:0]   rd_onehot_s;

    // Unpack commands and flag requesters that may win; reads wait while the tag FIFO is full.
    always_comb begin
        tag_full_s  = (tag_cnt_r == TAG_FULL);
        tag_empty_s = (tag_cnt_r == '0);
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_s[i]  = bus.req_cmd_i[i*CMD_W +: CMD_W];
            elig_s[i] = bus.req_valid_i[i] &&
                        !((cmd_s[i].rw == sdram_pkg::READ_CMD) && tag_full_s);
        end
    end

    // Round-robin pick: descending scan so the nearest index after last_grant wins.
    always_comb begin
        rr_pick_s = '0;
        pos_s     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos_s     = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
            rr_pick_s = elig_s[pos_s] ? pos_s : rr_pick_s;
        end
        pick_vld_s = |elig_s;
`ifdef SDRAM_ARB_PRIO0_EN
        if (elig_s[0]) begin
            pick_s = '0;
        end else begin
            pick_s = rr_pick_s;
        end
`else
        pick_s = rr_pick_s;
`endif
    end

    // Arbiter FSM next state and the combinational command-port outputs.
    always_comb begin
        state_nx_s   = state_r;
        grant_nx_s   = grant_r;
        last_nx_s    = last_grant_r;
        rw_nx_s      = burst_rw_r;
        beat_nx_s    = beat_cnt_r;
        ctrl_valid_s = 1'b0;
        ctrl_cmd_s   = '0;
        req_ready_s  = '0;
        push_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_nx_s = pick_s;
                    rw_nx_s    = cmd_s[pick_s].rw;
                    state_nx_s = ST_GRANT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                ctrl_valid_s         = bus.req_valid_i[grant_r];
                ctrl_cmd_s           = cmd_s[grant_r];
                ctrl_cmd_s.rw        = burst_rw_r;
                req_ready_s[grant_r] = bus.ctrl_ready_i;
                if (ctrl_valid_s && bus.ctrl_ready_i) begin
                    if (burst_rw_r == sdram_pkg::READ_CMD) begin
                        push_s     = 1'b1;
                        last_nx_s  = grant_r;
                        state_nx_s = ST_IDLE;
                    end else if (beat_cnt_r == LAST_BEAT) begin
                        beat_nx_s  = '0;
                        last_nx_s  = grant_r;
                        state_nx_s = ST_IDLE;
                    end else begin
                        beat_nx_s  = beat_cnt_r + BEAT_W'(1);
                    end
                end else begin
                    state_nx_s = ST_GRANT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and write-beat registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            burst_rw_r   <= 1'b0;
            beat_cnt_r   <= '0;
        end else begin
            state_r      <= state_nx_s;
            grant_r      <= grant_nx_s;
            last_grant_r <= last_nx_s;
            burst_rw_r   <= rw_nx_s;
            beat_cnt_r   <= beat_nx_s;
        end
    end

    assign head_tag_s  = tag_mem_r[rd_ptr_r];
    assign rd_hit_s    = bus.rd_valid_i && !tag_empty_s;
    assign pop_s       = rd_hit_s && (rd_beat_r == LAST_BEAT);
    assign rd_onehot_s = NUM_REQ'(1) << head_tag_s;

    // Tag FIFO of requester IDs with one entry per outstanding read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            tag_cnt_r <= '0;
            rd_beat_r <= '0;
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_r;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (rd_hit_s) begin
                rd_beat_r <= pop_s ? '0 : rd_beat_r + BEAT_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   tag_cnt_r <= tag_cnt_r + (PTR_W + 1)'(1);
                2'b01:   tag_cnt_r <= tag_cnt_r - (PTR_W + 1)'(1);
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    // Registered read return; untagged beats are dropped and latch the sticky error.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_valid_r <= '0;
            rd_data_r  <= '0;
            err_r      <= 1'b0;
        end else begin
            rd_valid_r <= rd_hit_s ? rd_onehot_s : '0;
            if (rd_hit_s) begin
                rd_data_r <= bus.rd_data_i;
            end
            err_r <= err_r | (bus.rd_valid_i && tag_empty_s);
        end
    end

    assign bus.ctrl_valid_o = ctrl_valid_s;
    assign bus.ctrl_cmd_o   = ctrl_cmd_s;
    assign bus.req_ready_o  = req_ready_s;
    assign bus.rd_valid_o   = rd_valid_r;
    assign bus.rd_data_o    = rd_data_r;
    assign bus.err_o        = err_r;

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Shares one SDRAM controller command port among NUM_REQ requesters, each issuing sdram_pkg::sdram_cmd_t commands over valid/ready.
- Round-robin arbitration.
- Write transactions are BURST_LEN beat-locked bursts. A read is a single command that returns BURST_LEN data beats.
- A requester-ID tag FIFO steers returned read beats back to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_LEN, sdram_pkg::BURST_LEN (8), beats per write burst and per read return.
- TAG_DEPTH, 4, maximum outstanding reads (power of 2).
- CMD_W, $bits(sdram_pkg::sdram_cmd_t) (42), packed command width (derived, not overridden).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester command valid.
- req_ready_o  out  NUM_REQ  per-requester command accept.
- req_cmd_i  in  NUM_REQ*CMD_W  packed sdram_cmd_t per requester; requester i occupies bits [i*CMD_W +: CMD_W].
- ctrl_valid_o  out  1  command valid to controller.
- ctrl_ready_i  in  1  controller accepts command.
- ctrl_cmd_o  out  CMD_W  muxed command to controller.
- rd_valid_i  in  1  read data beat from controller.
- rd_data_i  in  DATA_WIDTH  read data beat.
- rd_valid_o  out  NUM_REQ  one-hot read beat valid to the owning requester.
- rd_data_o  out  DATA_WIDTH  read data, shared by all requesters.
- err_o  out  1  sticky: read beat received with no outstanding tag.

Behaviour:
- Reset values (rstn_i low, asynchronous):
  - All outputs 0.
  - State IDLE, beat counter 0, tag FIFO empty, err_o 0.
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
  - A reset mid-burst or with reads outstanding discards everything; beats arriving after reset with no tag set err_o.
- Requester rule: once req_valid_i[i] is high, req_cmd_i[i] stays stable until the handshake (valid & ready).
- Eligibility: requester i is eligible when req_valid_i[i] = 1. A READ_CMD request is ineligible while the tag FIFO holds TAG_DEPTH entries.
- State IDLE:
  - req_ready_o = 0, ctrl_valid_o = 0.
  - If any requester is eligible, register grant = first eligible index after last_grant (wrapping modulo NUM_REQ), latch burst type = rw of that command, then go to GRANT.
  - If none is eligible, stay in IDLE.
- State GRANT:
  - ctrl_valid_o = req_valid_i[grant], ctrl_cmd_o = req_cmd_i[grant].
  - req_ready_o[grant] = ctrl_ready_i; all other ready bits 0.
  - On a READ handshake: push grant into the tag FIFO, set last_grant = grant, go to IDLE.
  - On a WRITE handshake: increment the beat counter. On the handshake with counter == BURST_LEN-1, clear the counter, set last_grant = grant, go to IDLE.
  - The grant is held for the whole write burst. A requester that drops valid mid-burst simply stalls the burst; no other requester is served.
  - ctrl_cmd_o.rw is forced to the latched burst type for every beat.
- Latency and throughput:
  - One cycle from eligible valid to ctrl_valid_o.
  - A read costs 2 cycles minimum; a write burst costs BURST_LEN+1 cycles minimum.
- Read return path (registered, 1-cycle latency):
  - On rd_valid_i: rd_data_o <= rd_data_i; rd_valid_o <= one-hot(tag at FIFO head).
  - A per-read beat counter pops the FIFO after beat BURST_LEN-1.
  - rd_valid_i with the FIFO empty: beat is dropped, rd_valid_o stays 0, err_o <= 1 (sticky until reset).
- Push and pop in the same cycle are both performed; the count is unchanged.
- Only ctrl_valid_o, ctrl_cmd_o and req_ready_o are combinational from registered grant/state plus inputs. ctrl_ready_i may depend on ctrl_valid_o; no other combinational path exists.

Optional Feature:
- Macro SDRAM_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If requester 0 is eligible in IDLE it is granted regardless of last_grant; the others rotate round-robin among themselves. An in-progress write burst is never pre-empted.
- Undefined: pure round-robin across all NUM_REQ requesters.

Test Plan:
- Reset → requesters 0 and 2 both issue a READ at addr 0x000100, ctrl_ready_i = 1 → requester 0 granted first, requester 2 second; 2 tags queued [0, 2].
- Controller returns 16 beats 0xA000..0xA00F → beats 0..7 appear on rd_valid_o = 0001 and beats 8..15 on 0100, each one cycle after rd_valid_i; FIFO then empty.
- Requester 1 issues an 8-beat WRITE while requester 3 holds a valid READ, with ctrl_ready_i toggling every cycle → all 8 write beats are forwarded contiguously with rw = 0; requester 3 is granted only after beat 8.
- Issue 4 READs with no data returned, then a 5th READ from requester 1 plus a WRITE from requester 2 → READ blocked, WRITE granted; after 8 read beats return, the READ is granted.
- rd_valid_i pulse with FIFO empty → rd_valid_o stays 0, err_o = 1 and holds; rstn_i low mid-write-burst → all outputs 0, state IDLE, err_o 0.
- With SDRAM_ARB_PRIO0_EN defined, requesters 0 and 1 continuously valid with READs → requester 0 granted every arbitration; without the macro, grants alternate 0, 1, 0, 1.
